insert_stuff: RTL and testbench

Byte-serialiser for the JPEG entropy path: accepts 32-bit packed bitstream words from the bit packer and emits one byte per cycle, MSB byte first. After every emitted 0xFF data byte it inserts a 0x00 stuff byte, unless a parallel no-stuff mask marks that byte as a marker or header byte. It sits between the bit packer and the MJPEG output port, and absorbs bursts in an internal word FIFO.

---
 rtl/insert_stuff_pkg.sv | 47 ++++
 rtl/insert_stuff_if.sv | 21 ++
 rtl/insert_stuff_sync_word_fifo.sv | 52 +++++
 rtl/insert_stuff.sv | 127 ++++++++++++
 tb/tb_insert_stuff.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/insert_stuff_pkg.sv
// Shared definitions for the JPEG byte-serialiser / 0xFF stuffer.
package insert_stuff_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned FIFO_W         = 2 * WORD_W;

  localparam logic [BYTE_W-1:0] STUFF_BYTE  = 8'h00;
  localparam logic [BYTE_W-1:0] MARKER_BYTE = 8'hFF;

  // Emit engine state; the byte index is carried alongside in byte_idx_t
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE  = 2'd1,
    ST_STUFF = 2'd2
  } state_t;

  typedef logic [1:0] byte_idx_t;
  localparam byte_idx_t LAST_IDX = 2'd3;

  // One FIFO entry: data word and its per-byte stuff-suppress mask
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] nostuff;
  } fifo_word_t;

  // Byte k of a word, k=0 being the most significant byte
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                 input byte_idx_t k);
    logic [BYTE_W-1:0] b;
    b = '0;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // A data byte needs a trailing stuff byte unless its mask byte is nonzero
  function automatic logic stuff_needed(input logic [BYTE_W-1:0] b,
                                        input logic [BYTE_W-1:0] m);
    return (b == MARKER_BYTE) && (m == '0);
  endfunction

endpackage

// File: rtl/insert_stuff_if.sv
// Producer-side word interface and output byte stream of insert_stuff.
interface insert_stuff_if;
  import insert_stuff_pkg::*;

  logic                enqueue;
  logic [WORD_W-1:0]   wdata;
  logic [WORD_W-1:0]   wdata_nostuff;
  logic                valid;
  logic [BYTE_W-1:0]   rdata;

  modport master (
    output enqueue, wdata, wdata_nostuff,
    input  valid, rdata
  );

  modport slave (
    input  enqueue, wdata, wdata_nostuff,
    output valid, rdata
  );

endinterface

// File: rtl/insert_stuff_sync_word_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a counter.
module sync_word_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Flags and head word; a full FIFO still accepts a push on a popping cycle
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_en = push && (!full || pop);
    rd_en = pop && !empty;
    dout  = mem[rd_ptr[AW-1:0]];
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Read/write pointers, wrapping mod 2*DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/insert_stuff.sv
// insert_stuff: serialises buffered 32-bit bitstream words into bytes, MSB
// byte first, inserting 0x00 after every unmasked 0xFF byte.
// Optional feature macro: INSERT_STUFF_OVERFLOW_CHECK_EN adds a sticky
// 'overflow' flag and a simulation-time report of every dropped word.
module insert_stuff
  import insert_stuff_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  insert_stuff_if.slave bus
);

  logic [FIFO_W-1:0] head_raw;
  fifo_word_t        head;
  fifo_word_t        cur;
  logic              full;
  logic              empty;
  logic              pop;

  state_t            state;
  byte_idx_t         idx;
  logic              valid_q;
  logic [BYTE_W-1:0] rdata_q;

  logic [BYTE_W-1:0] cur_byte;
  logic [BYTE_W-1:0] cur_mask;
  logic              need_stuff;
  logic              word_done;

  sync_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.enqueue),
    .din   ({bus.wdata, bus.wdata_nostuff}),
    .pop   (pop),
    .dout  (head_raw),
    .full  (full),
    .empty (empty)
  );

  // Current byte decode and pop decision: a new word is taken when idle or
  // when the last byte (or its stuff byte) of the current word is going out
  always_comb begin
    head       = fifo_word_t'(head_raw);
    cur_byte   = byte_sel(cur.data, idx);
    cur_mask   = byte_sel(cur.nostuff, idx);
    need_stuff = (state == ST_BYTE) && stuff_needed(cur_byte, cur_mask);
    word_done  = ((state == ST_BYTE) && (idx == LAST_IDX) && !need_stuff) ||
                 ((state == ST_STUFF) && (idx == LAST_IDX));
    pop        = ((state == ST_IDLE) || word_done) && !empty;
  end

  // Emit engine with registered byte output lagging the state by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cur     <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= (state != ST_IDLE);
      rdata_q <= (state == ST_BYTE) ? cur_byte : STUFF_BYTE;
      if (pop) begin
        state <= ST_BYTE;
        idx   <= '0;
        cur   <= head;
      end else begin
        case (state)
          ST_BYTE: begin
            if (need_stuff) begin
              state <= ST_STUFF;
            end else if (idx != LAST_IDX) begin
              idx <= idx + 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_STUFF: begin
            if (idx != LAST_IDX) begin
              state <= ST_BYTE;
              idx   <= idx + 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.valid = valid_q;
  assign bus.rdata = rdata_q;

`ifdef INSERT_STUFF_OVERFLOW_CHECK_EN
  logic overflow;
  logic drop;

  assign drop = bus.enqueue && full && !pop;

  // Sticky record that at least one word was dropped since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Report each dropped word during simulation
  always_ff @(posedge clk) begin
    if (!rst && drop) begin
      $error("insert_stuff: FIFO full, dropped word %h mask %h",
             bus.wdata, bus.wdata_nostuff);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_insert_stuff.sv
// Scoreboard bench for insert_stuff: a queue-based reference model predicts
// every output byte together with the clock edge after which it must appear.
module tb_insert_stuff;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  insert_stuff_if bus ();

  insert_stuff #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] mdl_data[$];
  logic [31:0] mdl_mask[$];
  int unsigned mdl_rem     = 0;
  bit          mdl_dropped = 1'b0;
  int unsigned edge_cnt    = 0;
  int unsigned n_checks    = 0;
  int unsigned n_pass      = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, got, want);
  endtask

  // Reference model for the upcoming clock edge: a bounded word queue and a
  // count of cycles left on the word being emitted
  task automatic model_edge(input bit en, input logic [31:0] w, input logic [31:0] m);
    int unsigned e;
    int unsigned n;
    bit          do_pop;
    bit          accept;
    logic [31:0] pw;
    logic [31:0] pm;
    logic [7:0]  b;
    logic [7:0]  mb;
    e      = edge_cnt + 1;
    do_pop = (mdl_rem <= 1) && (mdl_data.size() > 0);
    accept = en && ((mdl_data.size() < DEPTH) || do_pop);
    if (en && !accept) mdl_dropped = 1'b1;
    if (do_pop) begin
      pw = mdl_data.pop_front();
      pm = mdl_mask.pop_front();
      n  = 0;
      for (int k = 0; k < 4; k++) begin
        b  = pw[31 - 8*k -: 8];
        mb = pm[31 - 8*k -: 8];
        exp_q.push_back('{e + 1 + n, b});
        n++;
        if (b == 8'hFF && mb == 8'h00) begin
          exp_q.push_back('{e + 1 + n, 8'h00});
          n++;
        end
      end
      mdl_rem = n;
    end else if (mdl_rem > 0) begin
      mdl_rem--;
    end
    if (accept) begin
      mdl_data.push_back(w);
      mdl_mask.push_back(m);
    end
  endtask

  task automatic step(input bit en, input logic [31:0] w, input logic [31:0] m);
    @(negedge clk);
    bus.enqueue       = en;
    bus.wdata         = w;
    bus.wdata_nostuff = m;
    model_edge(en, w, m);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted between clock edges, in the middle of a word
  task automatic mid_reset();
    #2;
    rst         = 1'b1;
    bus.enqueue = 1'b0;
    mdl_data.delete();
    mdl_mask.delete();
    exp_q.delete();
    mdl_rem     = 0;
    mdl_dropped = 1'b0;
    #1;
    check("async_rst_valid", bus.valid, 0);
    check("async_rst_rdata", bus.rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
    return w;
  endfunction

  function automatic logic [31:0] rand_mask();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++)
      m[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    return m;
  endfunction

  // Monitor: every cycle either the next expected byte is due or the
  // output must be idle (valid=0, rdata=0)
  always @(negedge clk) begin
    exp_t it;
    if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
      it = exp_q.pop_front();
      check("byte_valid", bus.valid, 1);
      check("byte_rdata", bus.rdata, it.b);
    end else begin
      check("idle_valid", bus.valid, 0);
      check("idle_rdata", bus.rdata, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enqueue       = 1'b0;
    bus.wdata         = '0;
    bus.wdata_nostuff = '0;
    #1;
    check("reset_valid", bus.valid, 0);
    check("reset_rdata", bus.rdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);

    // Directed words from the byte-stuffing rules
    step(1'b1, 32'h12345678, 32'h00000000); idle(8);
    step(1'b1, 32'hFF00FFAB, 32'h00000000); idle(10);
    step(1'b1, 32'hFFD8FFE0, 32'hFFFFFFFF); idle(8);
    step(1'b1, 32'hFFD8FFE0, 32'h00FFFFFF); idle(8);

    // Back-to-back burst: no bubble between words
    step(1'b1, 32'hAAAAAAAA, 32'h00000000);
    step(1'b1, 32'hFFFFFFFF, 32'h00000000);
    step(1'b1, 32'h01020304, 32'h00000000);
    idle(24);

    // Reset in the middle of an emitted word
    step(1'b1, 32'h11223344, 32'h00000000);
    idle(3);
    mid_reset();
    idle(10);

    // Overflow: far more consecutive words than the FIFO and engine absorb
    for (int i = 0; i < int'(2*DEPTH + 6); i++) step(1'b1, rand_word(), rand_mask());
    idle(40);
`ifdef INSERT_STUFF_OVERFLOW_CHECK_EN
    check("overflow_flag", dut.overflow, mdl_dropped);
`endif
    idle(200);

    // Random traffic at a sustainable average rate
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) step(1'b1, rand_word(), rand_mask());
      else step(1'b0, '0, '0);
    end
    idle(250);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
